// File: rtl/disp_byte_sequencer.sv
// Steps a latched 32-bit result through a two-digit display one byte at a time.
// Stepping comes from a dwell timer (auto mode) or a debounced push-button.
module disp_byte_sequencer #(
  parameter int DWELL_CYCLES    = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic        result_valid,
  input  logic        btn_next,
  input  logic        auto_mode,
  output logic [7:0]  char,
  output logic [1:0]  byte_sel,
  output logic        loaded
);

  localparam int DW_RAW = $clog2(DWELL_CYCLES);
  localparam int DB_RAW = $clog2(DEBOUNCE_CYCLES);
  localparam int DW     = (DW_RAW < 1) ? 1 : DW_RAW;
  localparam int DB     = (DB_RAW < 1) ? 1 : DB_RAW;

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [DB-1:0] DB_LAST    = DB'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    EMPTY,
    SHOW
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   hold_q, hold_d;
  logic [1:0]    sel_d;
  logic [7:0]    char_d;
  logic          loaded_d;
  logic [DW-1:0] dwell_q, dwell_d;

  logic          btn_s1, btn_s2;
  logic [1:0]    fill;
  logic          armed;
  logic [DB-1:0] db_cnt;
  logic          db_level, db_prev;
  logic          btn_step;
  logic          auto_step;
  logic          step;

  function automatic logic [7:0] pick(
    input logic [31:0] w,
    input logic [1:0]  s
  );
    logic [7:0] b;
    b = 8'h00;
    unique case (s)
      2'd3: b = w[31:24];
      2'd2: b = w[23:16];
      2'd1: b = w[15:8];
      2'd0: b = w[7:0];
    endcase
    return b;
  endfunction

  // fill marks when btn_s2 reflects the pin rather than its reset value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      fill   <= 2'b00;
    end else begin
      btn_s1 <= btn_next;
      btn_s2 <= btn_s1;
      fill   <= {fill[0], 1'b1};
    end
  end

  // armed stays low until the button is seen released after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      db_prev <= db_level;
      if (fill[1] && !btn_s2) begin
        armed <= 1'b1;
      end
      if (btn_s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= btn_s2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign btn_step = db_level & ~db_prev & armed;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    sel_d     = byte_sel;
    char_d    = char;
    loaded_d  = loaded;
    dwell_d   = dwell_q;
    auto_step = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        dwell_d = '0;
      end
      SHOW: begin
        if (auto_mode) begin
          if (dwell_q == DWELL_LAST) begin
            auto_step = 1'b1;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end else begin
          dwell_d = '0;
        end
        step = auto_step | btn_step;
        if (step) begin
          sel_d   = byte_sel - 2'd1;
          dwell_d = '0;
          char_d  = pick(hold_q, sel_d);
        end
      end
    endcase
    // a new result overrides any step in the same cycle
    if (result_valid) begin
      state_d  = SHOW;
      hold_d   = result;
      sel_d    = 2'd3;
      dwell_d  = '0;
      loaded_d = 1'b1;
      char_d   = result[31:24];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      hold_q   <= 32'h0;
      byte_sel <= 2'd3;
      char     <= 8'h00;
      loaded   <= 1'b0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      byte_sel <= sel_d;
      char     <= char_d;
      loaded   <= loaded_d;
      dwell_q  <= dwell_d;
    end
  end

endmodule

// File: tb/tb_disp_byte_sequencer.sv
// Bench for disp_byte_sequencer with DWELL_CYCLES=8, DEBOUNCE_CYCLES=4.
// Random auto-mode traffic is scored against a byte-index reference model.
module tb_disp_byte_sequencer;

  localparam int DWELL = 8;
  localparam int DEB   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] result = 32'h0;
  logic        result_valid = 1'b0;
  logic        btn_next = 1'b0;
  logic        auto_mode = 1'b0;
  logic [7:0]  char;
  logic [1:0]  byte_sel;
  logic        loaded;

  int n_checks = 0;
  int n_fail   = 0;

  disp_byte_sequencer #(
    .DWELL_CYCLES(DWELL),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .result(result),
    .result_valid(result_valid),
    .btn_next(btn_next),
    .auto_mode(auto_mode),
    .char(char),
    .byte_sel(byte_sel),
    .loaded(loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int idx);
    logic [31:0] t;
    t = w >> (8 * idx);
    return t[7:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic btn);
    rst = 1'b1;
    result_valid = 1'b0;
    result = 32'h0;
    auto_mode = 1'b0;
    btn_next = btn;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    n_checks++;
    if ({char, byte_sel, loaded} !== {8'h00, 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: got char=%h sel=%0d loaded=%b, want 00/3/0",
               char, byte_sel, loaded);
    end
  endtask

  task automatic test_empty();
    apply_reset(1'b0);
    auto_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) btn_next = ~btn_next;
      cyc();
      n_checks++;
      if ({char, byte_sel, loaded} !== {8'h00, 2'd3, 1'b0}) begin
        n_fail++;
        $display("FAIL empty[%0d]: got char=%h sel=%0d loaded=%b, want 00/3/0",
                 i, char, byte_sel, loaded);
      end
    end
    btn_next = 1'b0;
  endtask

  task automatic test_auto_sequence();
    logic [31:0] w;
    int idx;
    w = 32'h3FC0_0001;
    apply_reset(1'b0);
    auto_mode = 1'b1;
    result = w;
    result_valid = 1'b1;
    cyc();
    result_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) cyc();
      idx = 3 - ((k / DWELL) % 4);
      n_checks++;
      if ({char, byte_sel, loaded} !== {byte_of(w, idx), 2'(idx), 1'b1}) begin
        n_fail++;
        $display("FAIL auto_seq[k=%0d]: got char=%h sel=%0d loaded=%b, want %h/%0d/1",
                 k, char, byte_sel, loaded, byte_of(w, idx), idx);
      end
    end
  endtask

  task automatic test_random_auto();
    logic [31:0] m_hold;
    int m_idx, m_cnt;
    bit m_loaded, rv;
    logic [7:0] ec;
    m_hold = 0; m_idx = 3; m_cnt = 0; m_loaded = 0;
    apply_reset(1'b0);
    auto_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rv = ($urandom_range(0, 15) == 0);
      result_valid = rv;
      result = $urandom;
      if ($urandom_range(0, 11) == 0) auto_mode = ~auto_mode;
      @(posedge clk);
      if (rv) begin
        m_hold = result; m_idx = 3; m_cnt = 0; m_loaded = 1;
      end else if (m_loaded && auto_mode) begin
        if (m_cnt == DWELL - 1) begin
          m_idx = (m_idx + 3) % 4;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end else begin
        m_cnt = 0;
      end
      #1;
      ec = m_loaded ? byte_of(m_hold, m_idx) : 8'h00;
      n_checks++;
      if ({char, byte_sel, loaded} !== {ec, 2'(m_idx), m_loaded}) begin
        n_fail++;
        $display("FAIL rand_auto[%0d]: got char=%h sel=%0d loaded=%b, want %h/%0d/%b",
                 i, char, byte_sel, loaded, ec, m_idx, m_loaded);
      end
    end
    result_valid = 1'b0;
  endtask

  task automatic test_manual();
    int lat;
    apply_reset(1'b0);
    auto_mode = 1'b0;
    result = 32'hDEAD_BEEF;
    result_valid = 1'b1;
    cyc();
    result_valid = 1'b0;
    repeat (5) begin
      btn_next = 1'b1;
      cyc();
      btn_next = 1'b0;
      repeat ($urandom_range(2, 5)) cyc();
    end
    btn_next = 1'b1;
    repeat (DEB - 1) cyc();
    btn_next = 1'b0;
    repeat (12) cyc();
    n_checks++;
    if ({char, byte_sel} !== {8'hDE, 2'd3}) begin
      n_fail++;
      $display("FAIL glitch_no_step: got char=%h sel=%0d, want DE/3", char, byte_sel);
    end
    lat = 0;
    btn_next = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (byte_sel != 2'd3 && lat == 0) lat = i;
    end
    btn_next = 1'b0;
    repeat (15) cyc();
    n_checks++;
    if (lat < 2 + DEB + 1 || lat > 2 + DEB + 3) begin
      n_fail++;
      $display("FAIL press_latency: got %0d cycles, want %0d..%0d",
               lat, 2 + DEB + 1, 2 + DEB + 3);
    end
    n_checks++;
    if ({char, byte_sel, loaded} !== {8'hAD, 2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL press_one_step: got char=%h sel=%0d loaded=%b, want AD/2/1",
               char, byte_sel, loaded);
    end
    btn_next = 1'b1;
    repeat (20) cyc();
    btn_next = 1'b0;
    repeat (15) cyc();
    n_checks++;
    if ({char, byte_sel} !== {8'hBE, 2'd1}) begin
      n_fail++;
      $display("FAIL press_second: got char=%h sel=%0d, want BE/1", char, byte_sel);
    end
  endtask

  task automatic test_coincident();
    apply_reset(1'b0);
    auto_mode = 1'b1;
    result = 32'h3FC0_0001;
    result_valid = 1'b1;
    cyc();
    result_valid = 1'b0;
    cyc();
    btn_next = 1'b1;
    for (int k = 2; k <= 20; k++) begin
      cyc();
      if (k == 8 || k == 15) begin
        n_checks++;
        if (byte_sel !== 2'd2) begin
          n_fail++;
          $display("FAIL coincide_k%0d: got sel=%0d, want 2", k, byte_sel);
        end
      end
      if (k == 16) begin
        n_checks++;
        if ({char, byte_sel} !== {8'h00, 2'd1}) begin
          n_fail++;
          $display("FAIL coincide_k16: got char=%h sel=%0d, want 00/1", char, byte_sel);
        end
      end
    end
    btn_next = 1'b0;
  endtask

  task automatic test_rv_wins();
    apply_reset(1'b0);
    auto_mode = 1'b1;
    result = 32'hAABB_CCDD;
    result_valid = 1'b1;
    cyc();
    result_valid = 1'b0;
    repeat (23) cyc();
    n_checks++;
    if ({char, byte_sel} !== {8'hCC, 2'd1}) begin
      n_fail++;
      $display("FAIL rv_pre: got char=%h sel=%0d, want CC/1", char, byte_sel);
    end
    result = 32'h1234_5678;
    result_valid = 1'b1;
    cyc();
    result_valid = 1'b0;
    n_checks++;
    if ({char, byte_sel, loaded} !== {8'h12, 2'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL rv_wins: got char=%h sel=%0d loaded=%b, want 12/3/1",
               char, byte_sel, loaded);
    end
    repeat (7) cyc();
    n_checks++;
    if ({char, byte_sel} !== {8'h12, 2'd3}) begin
      n_fail++;
      $display("FAIL rv_dwell_hold: got char=%h sel=%0d, want 12/3", char, byte_sel);
    end
    cyc();
    n_checks++;
    if ({char, byte_sel} !== {8'h34, 2'd2}) begin
      n_fail++;
      $display("FAIL rv_dwell_step: got char=%h sel=%0d, want 34/2", char, byte_sel);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(1'b0);
    auto_mode = 1'b1;
    result = 32'h3FC0_0001;
    result_valid = 1'b1;
    cyc();
    result_valid = 1'b0;
    repeat (27) cyc();
    n_checks++;
    if ({char, byte_sel, loaded} !== {8'h01, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_pre: got char=%h sel=%0d loaded=%b, want 01/0/1",
               char, byte_sel, loaded);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({char, byte_sel, loaded} !== {8'h00, 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got char=%h sel=%0d loaded=%b, want 00/3/0",
               char, byte_sel, loaded);
    end
    repeat (2) cyc();
    rst = 1'b0;
    repeat (12) cyc();
    n_checks++;
    if ({char, byte_sel, loaded} !== {8'h00, 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_wait: got char=%h sel=%0d loaded=%b, want 00/3/0",
               char, byte_sel, loaded);
    end
    result = 32'h55AA_33CC;
    result_valid = 1'b1;
    cyc();
    result_valid = 1'b0;
    for (int k = 0; k <= DWELL; k++) begin
      if (k > 0) cyc();
      n_checks++;
      if (k < DWELL && {char, byte_sel, loaded} !== {8'h55, 2'd3, 1'b1}) begin
        n_fail++;
        $display("FAIL reload_dwell[k=%0d]: got char=%h sel=%0d loaded=%b, want 55/3/1",
                 k, char, byte_sel, loaded);
      end else if (k == DWELL && {char, byte_sel} !== {8'hAA, 2'd2}) begin
        n_fail++;
        $display("FAIL reload_step: got char=%h sel=%0d, want AA/2", char, byte_sel);
      end
    end
  endtask

  task automatic test_btn_held_reset();
    apply_reset(1'b1);
    auto_mode = 1'b0;
    result = 32'hCAFE_F00D;
    result_valid = 1'b1;
    cyc();
    result_valid = 1'b0;
    repeat (30) cyc();
    n_checks++;
    if ({char, byte_sel, loaded} !== {8'hCA, 2'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL held_no_step: got char=%h sel=%0d loaded=%b, want CA/3/1",
               char, byte_sel, loaded);
    end
    btn_next = 1'b0;
    repeat (15) cyc();
    btn_next = 1'b1;
    repeat (20) cyc();
    btn_next = 1'b0;
    repeat (15) cyc();
    n_checks++;
    if ({char, byte_sel} !== {8'hFE, 2'd2}) begin
      n_fail++;
      $display("FAIL held_then_press: got char=%h sel=%0d, want FE/2", char, byte_sel);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_auto_sequence();
    test_random_auto();
    test_manual();
    test_coincident();
    test_rv_wins();
    test_reset_mid();
    test_btn_held_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
